// File: rtl/muldiv_unit_pkg.sv
// muldiv_unit_pkg: shared op/state types and iteration constants for the multiply/divide unit
package muldiv_unit_pkg;
  typedef enum logic {MD_MULTU = 1'b0, MD_DIVU = 1'b1} muldiv_op_t;
  typedef enum logic [1:0] {MD_IDLE, MD_MUL, MD_DIV} md_state_t;
  localparam int MD_ITERATIONS = 32;
  localparam int MD_CNT_W = 6;
  localparam logic [MD_CNT_W-1:0] MD_LAST = MD_CNT_W'(MD_ITERATIONS - 1);
endpackage

// File: rtl/muldiv_unit_hilo_regs.sv
// muldiv_unit_hilo_regs: HI/LO pair (clk, rst_n, we, hi_d/lo_d in; hi, lo, sel_hi-muxed rd out)
module muldiv_unit_hilo_regs #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             we,
  input  logic [WIDTH-1:0] hi_d,
  input  logic [WIDTH-1:0] lo_d,
  input  logic             sel_hi,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic [WIDTH-1:0] rd
);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      hi <= '0;
      lo <= '0;
    end else if (we) begin
      hi <= hi_d;
      lo <= lo_d;
    end
  assign rd = sel_hi ? hi : lo;
endmodule

// File: rtl/muldiv_unit.sv
// muldiv_unit: 32-cycle MULTU/DIVU (clk, rst_n, start/op/a/b, mf_req/mf_sel_hi in; busy, done, stall, hilo_out, hi, lo out)
module muldiv_unit
  import muldiv_unit_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  muldiv_op_t       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             mf_req,
  input  logic             mf_sel_hi,
  output logic             busy,
  output logic             done,
  output logic             stall,
  output logic [WIDTH-1:0] hilo_out,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);
  md_state_t           state;
  logic [MD_CNT_W-1:0] count;
  logic [2*WIDTH-1:0]  acc, acc_next;
  logic [WIDTH-1:0]    opb;
  logic [WIDTH:0]      sum, srem, trial;
  logic                last;
  assign busy = state != MD_IDLE;
  assign stall = busy & (start | mf_req);
  assign last = busy && count == MD_LAST;
  always_comb begin
    sum = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, opb} : '0);
    srem = acc[2*WIDTH-1:WIDTH-1];
    trial = srem - {1'b0, opb};
    acc_next = state == MD_DIV
      ? (trial[WIDTH] ? {srem[WIDTH-1:0], acc[WIDTH-2:0], 1'b0} : {trial[WIDTH-1:0], acc[WIDTH-2:0], 1'b1})
      : {sum, acc[WIDTH-1:1]};
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= MD_IDLE;
      count <= '0;
      acc <= '0;
      opb <= '0;
      done <= 1'b0;
    end else begin
      done <= last;
      if (!busy) begin
        if (start) begin
          state <= op == MD_DIVU ? MD_DIV : MD_MUL;
          count <= '0;
          acc <= {{WIDTH{1'b0}}, op == MD_DIVU ? a : b};
          opb <= op == MD_DIVU ? b : a;
        end
      end else begin
        acc <= acc_next;
        count <= count + 1'b1;
        if (last) state <= MD_IDLE;
      end
    end
  muldiv_unit_hilo_regs #(.WIDTH(WIDTH)) u_hilo (
    .clk   (clk),
    .rst_n (rst_n),
    .we    (last),
    .hi_d  (acc_next[2*WIDTH-1:WIDTH]),
    .lo_d  (acc_next[WIDTH-1:0]),
    .sel_hi(mf_sel_hi),
    .hi    (hi),
    .lo    (lo),
    .rd    (hilo_out)
  );
endmodule

// File: tb/tb_muldiv_unit.sv
// tb_muldiv_unit: directed self-checking bench for muldiv_unit
module tb_muldiv_unit;
  import muldiv_unit_pkg::*;
  logic        clk, rst_n, start, mf_req, mf_sel_hi;
  muldiv_op_t  op;
  logic [31:0] a, b;
  logic        busy, done, stall;
  logic [31:0] hilo_out, hi, lo;
  int          n_checks, n_errors;
  muldiv_unit #(.WIDTH(32)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .op       (op),
    .a        (a),
    .b        (b),
    .mf_req   (mf_req),
    .mf_sel_hi(mf_sel_hi),
    .busy     (busy),
    .done     (done),
    .stall    (stall),
    .hilo_out (hilo_out),
    .hi       (hi),
    .lo       (lo)
  );
  initial clk = 1'b0;
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic wait_done(input string tag);
    int cyc;
    bit bad;
    cyc = 0;
    bad = 0;
    while (busy && cyc < 100) begin
      if (!stall || done) bad = 1;
      cyc++;
      @(posedge clk);
      #1;
    end
    check({tag, "_busy_cycles"}, 32'(cyc), 32);
    check({tag, "_stall_while_busy"}, {31'b0, bad}, 32'd0);
    check({tag, "_done"}, {31'b0, done}, 32'd1);
  endtask
  task automatic run_op(input string tag, input muldiv_op_t o, input logic [31:0] x, input logic [31:0] y,
                        input logic [31:0] ehi, input logic [31:0] elo);
    start = 1'b1;
    op = o;
    a = x;
    b = y;
    mf_req = 1'b0;
    @(posedge clk);
    #1;
    start = 1'b0;
    mf_req = 1'b1;
    mf_sel_hi = 1'b1;
    check({tag, "_busy_after_accept"}, {31'b0, busy}, 32'd1);
    wait_done(tag);
    check({tag, "_hi"}, hi, ehi);
    check({tag, "_lo"}, lo, elo);
    check({tag, "_mfhi"}, hilo_out, ehi);
    check({tag, "_stall_idle"}, {31'b0, stall}, 32'd0);
    mf_sel_hi = 1'b0;
    #1;
    check({tag, "_mflo"}, hilo_out, elo);
    mf_req = 1'b0;
    @(posedge clk);
    #1;
    check({tag, "_done_one_cycle"}, {31'b0, done}, 32'd0);
  endtask
  initial begin
    bit bad;
    n_checks = 0;
    n_errors = 0;
    rst_n = 1'b0;
    start = 1'b0;
    op = MD_MULTU;
    a = '0;
    b = '0;
    mf_req = 1'b1;
    mf_sel_hi = 1'b1;
    #1;
    check("rst_busy", {31'b0, busy}, 32'd0);
    check("rst_done", {31'b0, done}, 32'd0);
    check("rst_stall", {31'b0, stall}, 32'd0);
    check("rst_hilo_out", hilo_out, 32'd0);
    check("rst_hi", hi, 32'd0);
    check("rst_lo", lo, 32'd0);
    mf_req = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    run_op("mul_7x6", MD_MULTU, 32'd7, 32'd6, 32'd0, 32'd42);
    run_op("mul_max", MD_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001);
    run_op("div_100_7", MD_DIVU, 32'd100, 32'd7, 32'd2, 32'd14);
    run_op("div_by_zero", MD_DIVU, 32'h12345678, 32'd0, 32'h12345678, 32'hFFFFFFFF);
    start = 1'b1;
    op = MD_MULTU;
    a = 32'd3;
    b = 32'd5;
    @(posedge clk);
    #1;
    op = MD_DIVU;
    a = 32'd50;
    b = 32'd4;
    wait_done("b2b_first");
    check("b2b_first_hi", hi, 32'd0);
    check("b2b_first_lo", lo, 32'd15);
    @(posedge clk);
    #1;
    check("b2b_second_accepted", {31'b0, busy}, 32'd1);
    check("b2b_done_dropped", {31'b0, done}, 32'd0);
    check("b2b_lo_held", lo, 32'd15);
    start = 1'b0;
    mf_req = 1'b1;
    wait_done("b2b_second");
    check("b2b_second_hi", hi, 32'd2);
    check("b2b_second_lo", lo, 32'd12);
    mf_req = 1'b0;
    @(posedge clk);
    #1;
    start = 1'b1;
    op = MD_MULTU;
    a = 32'd7;
    b = 32'd6;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (9) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check("abort_busy", {31'b0, busy}, 32'd0);
    check("abort_done", {31'b0, done}, 32'd0);
    check("abort_hi", hi, 32'd0);
    check("abort_lo", lo, 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    bad = 0;
    repeat (40) begin
      @(posedge clk);
      #1;
      if (done || busy) bad = 1;
    end
    check("abort_no_done", {31'b0, bad}, 32'd0);
    run_op("div_9_3", MD_DIVU, 32'd9, 32'd3, 32'd0, 32'd3);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
